// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: operation codes, FSM states
// and the shift-class helper used by the control decoder.
package alu_pkg;

   localparam logic [3:0] OP_SLL     = 4'b0000;
   localparam logic [3:0] OP_SRL     = 4'b0001;
   localparam logic [3:0] OP_SRA     = 4'b0010;
   localparam logic [3:0] OP_SLLV    = 4'b0011;
   localparam logic [3:0] OP_SRLV    = 4'b0100;
   localparam logic [3:0] OP_SRAV    = 4'b0101;
   localparam logic [3:0] OP_ADD     = 4'b0110;
   localparam logic [3:0] OP_SUB     = 4'b0111;
   localparam logic [3:0] OP_OR      = 4'b1000;
   localparam logic [3:0] OP_XOR     = 4'b1001;
   localparam logic [3:0] OP_AND     = 4'b1010;
   localparam logic [3:0] OP_NOR     = 4'b1011;
   localparam logic [3:0] OP_SLT     = 4'b1100;
   localparam logic [3:0] OP_LUI     = 4'b1101;
   localparam logic [3:0] OP_ILLEGAL = 4'b1110;
   localparam logic [3:0] OP_COMPARE = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } alu_state_t;

   // Codes 0..5 are the six shift operations.
   function automatic logic is_shift_op(input logic [3:0] code);
      return (code <= OP_SRAV);
   endfunction

   // Variable shifts take their amount from operand A.
   function automatic logic is_var_shift(input logic [3:0] code);
      return (code == OP_SLLV) || (code == OP_SRLV) || (code == OP_SRAV);
   endfunction

   function automatic logic is_right_shift(input logic [3:0] code);
      return (code == OP_SRL) || (code == OP_SRA) ||
             (code == OP_SRLV) || (code == OP_SRAV);
   endfunction

   function automatic logic is_arith_shift(input logic [3:0] code);
      return (code == OP_SRA) || (code == OP_SRAV);
   endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle shifter: holds the operand, direction, fill mode and a
// down-counter of remaining shifts. o_next is the value after the next step.
module alu_serial_shifter #(
   parameter int NB_DATA = 32
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_load,
   input  logic [NB_DATA-1:0] i_data,
   input  logic [4:0]         i_amount,
   input  logic               i_right,
   input  logic               i_arith,
   output logic [NB_DATA-1:0] o_data,
   output logic [NB_DATA-1:0] o_next,
   output logic [4:0]         o_count
);

   logic [NB_DATA-1:0] data_q;
   logic [4:0]         count_q;
   logic               right_q;
   logic               arith_q;
   logic               fill;

   // Single-step shift of the held operand; arithmetic fill copies the MSB.
   always_comb begin
      fill   = arith_q & data_q[NB_DATA-1];
      o_next = right_q ? {fill, data_q[NB_DATA-1:1]} : {data_q[NB_DATA-2:0], 1'b0};
   end

   // Load on accept, then shift and count down until the counter reaches zero.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         data_q  <= '0;
         count_q <= '0;
         right_q <= 1'b0;
         arith_q <= 1'b0;
      end else if (i_load) begin
         data_q  <= i_data;
         count_q <= i_amount;
         right_q <= i_right;
         arith_q <= i_arith;
      end else if (count_q != 5'd0) begin
         data_q  <= o_next;
         count_q <= count_q - 5'd1;
      end
   end

   assign o_data  = data_q;
   assign o_count = count_q;

endmodule

// File: rtl/alu_exec.sv
// ALU execute stage: single-cycle combinational ops, serial shifts, and a
// valid/ready handshake on both sides driven by an IDLE/SHIFT/DONE FSM.
module alu_exec
   import alu_pkg::*;
#(
   parameter int NB_DATA = 32,
   parameter int NB_CTRL = 4
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [NB_CTRL-1:0] i_alucontrol,
   input  logic [NB_DATA-1:0] i_data_a,
   input  logic [NB_DATA-1:0] i_data_b,
   input  logic [4:0]         i_shamt,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [NB_DATA-1:0] o_result,
   output logic               o_zero,
   output logic               o_illegal
);

   alu_state_t         state_q, state_d;
   logic [NB_DATA-1:0] result_q, result_d;
   logic               zero_q, zero_d;
   logic               illegal_q, illegal_d;
   logic [3:0]         ctrl;
   logic [NB_DATA-1:0] alu_res;
   logic [4:0]         amount;
   logic               load;
   logic [NB_DATA-1:0] sh_data;
   logic [NB_DATA-1:0] sh_next;
   logic [4:0]         sh_count;

   assign ctrl   = i_alucontrol[3:0];
   assign amount = is_var_shift(ctrl) ? i_data_a[4:0] : i_shamt;

   alu_serial_shifter #(
      .NB_DATA (NB_DATA)
   ) u_shifter (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_load   (load),
      .i_data   (i_data_b),
      .i_amount (amount),
      .i_right  (is_right_shift(ctrl)),
      .i_arith  (is_arith_shift(ctrl)),
      .o_data   (sh_data),
      .o_next   (sh_next),
      .o_count  (sh_count)
   );

   // Single-cycle operations; shifts and the reserved code yield zero here.
   always_comb begin
      alu_res = '0;
      case (ctrl)
         OP_ADD:     alu_res = i_data_a + i_data_b;
         OP_SUB:     alu_res = i_data_a - i_data_b;
         OP_COMPARE: alu_res = i_data_a - i_data_b;
         OP_OR:      alu_res = i_data_a | i_data_b;
         OP_XOR:     alu_res = i_data_a ^ i_data_b;
         OP_AND:     alu_res = i_data_a & i_data_b;
         OP_NOR:     alu_res = ~(i_data_a | i_data_b);
         OP_SLT:     alu_res = {{(NB_DATA-1){1'b0}},
                                ($signed(i_data_a) < $signed(i_data_b))};
         OP_LUI:     alu_res = i_data_b << 16;
         default:    alu_res = '0;
      endcase
   end

   // Next-state and result-capture logic; results are captured on entry to DONE.
   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      zero_d    = zero_q;
      illegal_d = illegal_q;
      load      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_valid) begin
               if (is_shift_op(ctrl)) begin
                  if (amount == 5'd0) begin
                     result_d  = i_data_b;
                     zero_d    = (i_data_b == '0);
                     illegal_d = 1'b0;
                     state_d   = ST_DONE;
                  end else begin
                     load    = 1'b1;
                     state_d = ST_SHIFT;
                  end
               end else begin
                  result_d  = alu_res;
                  zero_d    = (alu_res == '0);
                  illegal_d = (ctrl == OP_ILLEGAL);
                  state_d   = ST_DONE;
               end
            end
         end
         ST_SHIFT: begin
            // Counter at 1 means this edge performs the final shift.
            if (sh_count == 5'd1) begin
               result_d  = sh_next;
               zero_d    = (sh_next == '0);
               illegal_d = 1'b0;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: begin
            if (i_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and result registers; reset aborts any operation in flight.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q   <= ST_IDLE;
         result_q  <= '0;
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         illegal_q <= illegal_d;
      end
   end

   assign o_ready   = (state_q == ST_IDLE);
   assign o_valid   = (state_q == ST_DONE);
   assign o_result  = result_q;
   assign o_zero    = zero_q;
   assign o_illegal = illegal_q;

   logic unused_ok;
   assign unused_ok = ^sh_data;

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have parameter NB_DATA, default 32, datapath width.
REQ-002 SHALL have parameter NB_CTRL, default 4, ALU control code width.
REQ-003 SHALL have port i_clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port i_reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_valid  input  1  upstream operation offered.
REQ-006 SHALL have port o_ready  output  1  block can accept an operation.
REQ-007 SHALL have port i_alucontrol  input  NB_CTRL  operation code.
REQ-008 SHALL have port i_data_a  input  NB_DATA  operand A (rs).
REQ-009 SHALL have port i_data_b  input  NB_DATA  operand B (rt / sign-extended immediate).
REQ-010 SHALL have port i_shamt  input  5  fixed shift amount.
REQ-011 SHALL have port o_valid  output  1  result available.
REQ-012 SHALL have port i_ready  input  1  downstream accepts result.
REQ-013 SHALL have ports o_result (NB_DATA), o_zero (1, o_result==0), o_illegal (1, code 1110 received).

Function
REQ-014 SHALL decode codes: 0000 SLL, 0001 SRL, 0010 SRA, 0011 SLLV, 0100 SRLV, 0101 SRAV, 0110 ADD, 0111 SUB, 1000 OR, 1001 XOR, 1010 AND, 1011 NOR, 1100 SLT, 1101 LUI, 1111 COMPARE (A-B), 1110 reserved.
REQ-015 SHALL implement FSM states IDLE, SHIFT, DONE; o_ready=1 only in IDLE; o_valid=1 only in DONE.
REQ-016 SHALL accept an operation only on a cycle with i_valid=1 and o_ready=1; inputs are ignored otherwise.
REQ-017 On accepting a non-shift op SHALL register result and flags and enter DONE (o_valid one cycle after accept).
REQ-018 Shifts SHALL operate on B; amount is i_shamt for SLL/SRL/SRA and i_data_a[4:0] for SLLV/SRLV/SRAV, latched at accept.
REQ-019 Shift with amount N=0 SHALL enter DONE directly with o_result=B; N>0 SHALL enter SHIFT, shift one bit per cycle, decrement counter, enter DONE after the Nth shift (o_valid N+1 cycles after accept).
REQ-020 SRA/SRAV SHALL replicate B[NB_DATA-1]; logical shifts SHALL fill zeros.
REQ-021 ADD/SUB/COMPARE SHALL wrap modulo 2^NB_DATA, no overflow detection.
REQ-022 SLT SHALL compare signed, o_result = 1 or 0 zero-extended.
REQ-023 LUI SHALL produce {B[15:0], 16'b0}.
REQ-024 Code 1110 SHALL produce o_result=0, o_zero=1, o_illegal=1 in DONE; o_illegal=0 for all other codes.
REQ-025 o_zero SHALL be computed from the final result and registered with it.
REQ-026 In DONE, o_result/o_zero/o_illegal SHALL hold stable until i_ready=1; then FSM returns to IDLE next cycle.
REQ-027 i_valid during SHIFT or DONE SHALL not disturb the in-flight operation.

Reset
REQ-028 i_reset=1 at a rising edge SHALL force IDLE, o_ready=1, o_valid=0, o_result=0, o_zero=0, o_illegal=0, shift counter=0.
REQ-029 Reset SHALL take priority over accept and abort any SHIFT or DONE in progress; no result emitted.

Structure
REQ-030 Operation code localparams (16 codes) and FSM state encoding SHALL live in shared package alu_pkg, reused by the ALU control decoder.
REQ-031 Serial shift datapath (operand register, direction, arithmetic fill, down-counter) SHALL be sub-module alu_serial_shifter; FSM and combinational ops stay in alu_exec.

Verification
REQ-032 ADD A=0xFFFFFFFF, B=0x00000001 -> o_valid 1 cycle after accept, o_result=0x00000000, o_zero=1.
REQ-033 SRA B=0x80000000, i_shamt=4 -> o_valid 5 cycles after accept, o_result=0xF8000000; o_ready=0 throughout.
REQ-034 SLLV A=0x00000020 (amount 0), B=0x12345678 -> o_valid 1 cycle after accept, o_result=0x12345678.
REQ-035 SLT A=0xFFFFFFFE (-2), B=0x00000001 -> o_result=1; LUI B=0x0000ABCD -> o_result=0xABCD0000; code 1110 -> o_illegal=1, o_result=0.
REQ-036 SRL with amount 31, hold i_ready=0 3 cycles in DONE, then i_ready=1 -> outputs stable while held, IDLE next cycle; reset asserted at SHIFT cycle 10 -> IDLE, o_valid never rises.
